// File: rtl/nand_chain_seq_if.sv
// Operand/result handshake bundle for nand_chain_seq.
// master = producer/consumer side, slave = the sequencer.
interface nand_chain_seq_if #(
    parameter int STAGES = 3
);
    logic              in_valid;
    logic              in_ready;
    logic              in_first;
    logic [STAGES-1:0] in_ops;
    logic              out_valid;
    logic              out_ready;
    logic [STAGES-1:0] stage_out;
    logic              result;

    modport master (
        output in_valid, in_first, in_ops, out_ready,
        input  in_ready, out_valid, stage_out, result
    );

    modport slave (
        input  in_valid, in_first, in_ops, out_ready,
        output in_ready, out_valid, stage_out, result
    );
endinterface

// File: rtl/nand_chain_seq.sv
// Cascaded NAND chain evaluated one stage per clock on a single shared NAND unit.
// Operands are latched on acceptance; per-stage results are held until the consumer takes them.
module nand_chain_seq #(
    parameter int STAGES = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    nand_chain_seq_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t            state;
    logic              first_reg;
    logic [STAGES-1:0] op_reg;
    logic [STAGES-1:0] stage_reg;
    logic [IDX_W-1:0]  stage_idx;
    logic              nand_prev;
    logic              nand_op;
    logic              nand_out;
    logic              last_stage;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // Operand mux feeding the shared NAND: stage 0 chains from first_reg, later stages from the previous result.
    always_comb begin
        nand_prev = first_reg;
        nand_op   = op_reg[0];
        for (int k = 1; k < STAGES; k++) begin
            if (stage_idx == IDX_W'(k)) begin
                nand_prev = stage_reg[k-1];
                nand_op   = op_reg[k];
            end
        end
        nand_out = nand2(nand_op, nand_prev);
    end

    assign last_stage = (stage_idx == IDX_W'(STAGES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            first_reg  <= 1'b0;
            op_reg     <= '0;
            stage_reg  <= '0;
            stage_idx  <= '0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        first_reg <= bus.in_first;
                        op_reg    <= bus.in_ops;
                        stage_reg <= '0;
                        stage_idx <= '0;
                        state     <= EVAL;
                    end
                end
                EVAL: begin
                    for (int k = 0; k < STAGES; k++) begin
                        if (stage_idx == IDX_W'(k)) begin
                            stage_reg[k] <= nand_out;
                        end
                    end
                    if (last_stage) begin
                        state <= DONE;
                    end else begin
                        stage_idx <= stage_idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        done_count <= done_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything visible to the outside is a register or a state decode; in_ready is also held low during reset.
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = (state == DONE);
    assign bus.stage_out = stage_reg;
    assign bus.result    = stage_reg[STAGES-1];
    assign busy          = (state != IDLE);
endmodule
